data_memory_responder: RTL and testbench

- Responder (memory side) of the CPU load/store interface: accepts one load or store request at a time from the core's memory stage and returns read data or a store acknowledgement.
- Word-organised data RAM with byte and halfword access lanes, sign/zero extension for loads, and a configurable wait-state count.
- Sits beside the register file and ALU. Fed by the Memread/Memwrite decode from the main control unit; load data returns to the write-back mux.

---
 rtl/data_memory_responder_if.sv | 28 ++
 rtl/data_memory_responder.sv | 175 +++++++++++++++++
 tb/tb_data_memory_responder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/data_memory_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_memory_responder_if : load/store request and response bus            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface data_memory_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [2:0]  req_funct3;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_funct3, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_funct3, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface
`default_nettype wire

// File: rtl/data_memory_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_memory_responder : word RAM answering one CPU load/store at a time    |
// | Option macro DATA_MEMORY_MISALIGN_TRAP_EN traps misaligned accesses. Rev 1.0|
// +----------------------------------------------------------------------------+
module data_memory_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   data_memory_responder_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam int         c_aw       = ADDR_WIDTH + 2;
   localparam logic [3:0] c_cnt_init = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              ready_q, ready_d;
   logic              write_q, write_d;
   logic [c_aw-1:0]   addr_q, addr_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              resp_valid_q, resp_valid_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [31:0]       mem_q [2**ADDR_WIDTH];
   logic [31:0]       rword_q;

   logic              illegal, misalign, err, mem_we;
   logic [3:0]        lane_en;
   logic [31:0]       lane_data;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [31:0]       ld_data;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic              unused_addr_hi;

   assign unused_addr_hi = ^bus.req_addr[31:c_aw];
   assign word_idx       = addr_q[c_aw-1:2];

   // Unsigned-load codes are meaningless for stores, hence funct3[2] with write.
   assign illegal = (funct3_q == 3'b011) || (funct3_q == 3'b110) ||
                    (funct3_q == 3'b111) || (write_q && funct3_q[2]);
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
   assign misalign = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                     ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif
   assign err    = illegal || misalign;
   assign mem_we = (state_q == ACCESS) && write_q && !err;

   always_comb begin
      lane_en   = 4'b1111;
      lane_data = wdata_q;
      case (funct3_q[1:0])
         2'b00: begin
            lane_en   = 4'b0001 << addr_q[1:0];
            lane_data = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            lane_en   = addr_q[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{wdata_q[15:0]}};
         end
         default: ;
      endcase
   end

   assign ld_byte = rword_q[{addr_q[1:0], 3'b000} +: 8];
   assign ld_half = addr_q[1] ? rword_q[31:16] : rword_q[15:0];

   always_comb begin
      ld_data = rword_q;
      case (funct3_q)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_data = {24'd0, ld_byte};
         3'b101:  ld_data = {16'd0, ld_half};
         default: ;
      endcase
   end

   // Synchronous RAM: the ACCESS edge writes lanes and latches the read word.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) mem_q[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
         end
      end
      rword_q <= mem_q[word_idx];
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      write_d      = write_q;
      addr_d       = addr_q;
      funct3_d     = funct3_q;
      wdata_d      = wdata_q;
      resp_valid_d = resp_valid_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid && ready_q) begin
               write_d  = bus.req_write;
               addr_d   = bus.req_addr[c_aw-1:0];
               funct3_d = bus.req_funct3;
               wdata_d  = bus.req_wdata;
               cnt_d    = c_cnt_init;
               state_d  = (LATENCY > 0) ? WAIT : ACCESS;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) state_d = ACCESS;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ACCESS: state_d = RESP;
         RESP: begin
            // First RESP cycle formats the latched word; later cycles hold it.
            if (!resp_valid_q) begin
               resp_valid_d = 1'b1;
               err_d        = err;
               rdata_d      = (write_q || err) ? 32'd0 : ld_data;
            end else if (bus.resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         ready_q      <= 1'b0;
         write_q      <= 1'b0;
         addr_q       <= '0;
         funct3_q     <= 3'd0;
         wdata_q      <= 32'd0;
         resp_valid_q <= 1'b0;
         rdata_q      <= 32'd0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ready_q      <= ready_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         funct3_q     <= funct3_d;
         wdata_q      <= wdata_d;
         resp_valid_q <= resp_valid_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
      end
   end

   assign bus.req_ready  = ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;
endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_data_memory_responder : directed self-checking bench for the responder  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_data_memory_responder;
   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_pass   = 0;

   data_memory_responder_if bus ();

   data_memory_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Issues one request and collects its response; latency counts edges after acceptance.
   task automatic do_req(input logic wr, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat);
      int guard = 0;
      while (!bus.req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
      bus.req_valid  = 1'b1;
      bus.req_write  = wr;
      bus.req_addr   = addr;
      bus.req_funct3 = f3;
      bus.req_wdata  = wd;
      @(posedge clk); #1;
      bus.req_valid  = 1'b0;
      lat = 0;
      while (!bus.resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
      rd = bus.resp_rdata;
      er = bus.resp_err;
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 32'd0;
      bus.req_funct3 = 3'd0; bus.req_wdata = 32'd0; bus.resp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (bus.req_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", bus.req_ready); else n_pass++;
      n_checks++; if (bus.resp_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.resp_valid); else n_pass++;
      n_checks++; if (bus.resp_rdata !== 32'd0) $display("FAIL reset_rdata: got %h expected 00000000", bus.resp_rdata); else n_pass++;
      n_checks++; if (bus.resp_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", bus.resp_err); else n_pass++;
      reset = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL ready_after_reset: got %b expected 1", bus.req_ready); else n_pass++;
   endtask

   task automatic test_word;
      logic [31:0] rd; logic er; int lat;
      do_req(1'b1, 32'h010, 3'b010, 32'hDEADBEEF, rd, er, lat);
      n_checks++; if (lat !== 4) $display("FAIL sw_latency: got %0d expected 4", lat); else n_pass++;
      n_checks++; if ({er, rd} !== 33'd0) $display("FAIL sw_resp: got err=%b rdata=%h expected err=0 rdata=00000000", er, rd); else n_pass++;
      do_req(1'b0, 32'h010, 3'b010, 32'd0, rd, er, lat);
      n_checks++; if (lat !== 4) $display("FAIL lw_latency: got %0d expected 4", lat); else n_pass++;
      n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL lw_data: got %h expected deadbeef", rd); else n_pass++;
      n_checks++; if (er !== 1'b0) $display("FAIL lw_err: got %b expected 0", er); else n_pass++;
   endtask

   task automatic test_extend;
      logic [31:0] rd; logic er; int lat;
      do_req(1'b0, 32'h013, 3'b000, 32'd0, rd, er, lat);
      n_checks++; if (rd !== 32'hFFFFFFDE) $display("FAIL lb: got %h expected ffffffde", rd); else n_pass++;
      do_req(1'b0, 32'h013, 3'b100, 32'd0, rd, er, lat);
      n_checks++; if (rd !== 32'h000000DE) $display("FAIL lbu: got %h expected 000000de", rd); else n_pass++;
      do_req(1'b0, 32'h012, 3'b001, 32'd0, rd, er, lat);
      n_checks++; if (rd !== 32'hFFFFDEAD) $display("FAIL lh: got %h expected ffffdead", rd); else n_pass++;
      do_req(1'b0, 32'h010, 3'b101, 32'd0, rd, er, lat);
      n_checks++; if (rd !== 32'h0000BEEF) $display("FAIL lhu: got %h expected 0000beef", rd); else n_pass++;
   endtask

   task automatic test_lanes;
      logic [31:0] rd; logic er; int lat;
      do_req(1'b1, 32'h011, 3'b000, 32'hAAAAAA55, rd, er, lat);
      do_req(1'b0, 32'h010, 3'b010, 32'd0, rd, er, lat);
      n_checks++; if (rd !== 32'hDEAD55EF) $display("FAIL sb_lane: got %h expected dead55ef", rd); else n_pass++;
      do_req(1'b1, 32'h012, 3'b001, 32'hFFFF1234, rd, er, lat);
      do_req(1'b0, 32'h010, 3'b010, 32'd0, rd, er, lat);
      n_checks++; if (rd !== 32'h123455EF) $display("FAIL sh_lane: got %h expected 123455ef", rd); else n_pass++;
      do_req(1'b1, 32'h1010, 3'b010, 32'hCAFEF00D, rd, er, lat);
      do_req(1'b0, 32'h010, 3'b010, 32'd0, rd, er, lat);
      n_checks++; if (rd !== 32'hCAFEF00D) $display("FAIL addr_wrap: got %h expected cafef00d", rd); else n_pass++;
   endtask

   task automatic test_backpressure;
      logic [31:0] rd; logic er; int lat; int guard = 0;
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h010;
      bus.req_funct3 = 3'b010; bus.req_wdata = 32'd0;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      while (!bus.resp_valid && guard < 40) begin @(posedge clk); #1; guard++; end
      // A competing store is presented while the response is stalled.
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_wdata = 32'h0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if ({bus.resp_valid, bus.req_ready, bus.resp_rdata} !== {1'b1, 1'b0, 32'hCAFEF00D})
            $display("FAIL stall_%0d: got valid=%b ready=%b rdata=%h expected valid=1 ready=0 rdata=cafef00d",
                     i, bus.resp_valid, bus.req_ready, bus.resp_rdata);
         else n_pass++;
      end
      bus.req_valid = 1'b0; bus.req_write = 1'b0;
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
      n_checks++; if ({bus.req_ready, bus.resp_valid} !== 2'b10) $display("FAIL release: got ready=%b valid=%b expected ready=1 valid=0", bus.req_ready, bus.resp_valid); else n_pass++;
      do_req(1'b0, 32'h010, 3'b010, 32'd0, rd, er, lat);
      n_checks++; if (rd !== 32'hCAFEF00D) $display("FAIL ignored_req: got %h expected cafef00d", rd); else n_pass++;
   endtask

   task automatic test_reset_mid;
      logic [31:0] rd; logic er; int lat;
      do_req(1'b1, 32'h020, 3'b010, 32'h0BADF00D, rd, er, lat);
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h020;
      bus.req_funct3 = 3'b010; bus.req_wdata = 32'h11111111;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      n_checks++; if ({bus.resp_valid, bus.req_ready} !== 2'b00) $display("FAIL mid_reset: got valid=%b ready=%b expected valid=0 ready=0", bus.resp_valid, bus.req_ready); else n_pass++;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL mid_reset_idle: got ready=%b expected 1", bus.req_ready); else n_pass++;
      do_req(1'b0, 32'h020, 3'b010, 32'd0, rd, er, lat);
      n_checks++; if (rd !== 32'h0BADF00D) $display("FAIL store_dropped: got %h expected 0badf00d", rd); else n_pass++;
   endtask

   task automatic test_illegal;
      logic [31:0] rd; logic er; int lat;
      do_req(1'b0, 32'h010, 3'b011, 32'd0, rd, er, lat);
      n_checks++; if ({er, rd} !== {1'b1, 32'd0}) $display("FAIL illegal_load: got err=%b rdata=%h expected err=1 rdata=00000000", er, rd); else n_pass++;
      do_req(1'b1, 32'h010, 3'b110, 32'd0, rd, er, lat);
      n_checks++; if (er !== 1'b1) $display("FAIL illegal_store: got err=%b expected 1", er); else n_pass++;
      do_req(1'b1, 32'h010, 3'b100, 32'd0, rd, er, lat);
      n_checks++; if (er !== 1'b1) $display("FAIL unsigned_store: got err=%b expected 1", er); else n_pass++;
      do_req(1'b0, 32'h010, 3'b010, 32'd0, rd, er, lat);
      n_checks++; if (rd !== 32'hCAFEF00D) $display("FAIL illegal_no_write: got %h expected cafef00d", rd); else n_pass++;
   endtask

   task automatic test_misalign;
      logic [31:0] rd; logic er; int lat;
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
      do_req(1'b0, 32'h012, 3'b010, 32'd0, rd, er, lat);
      n_checks++; if ({er, rd} !== {1'b1, 32'd0}) $display("FAIL misalign_lw: got err=%b rdata=%h expected err=1 rdata=00000000", er, rd); else n_pass++;
      do_req(1'b0, 32'h011, 3'b001, 32'd0, rd, er, lat);
      n_checks++; if ({er, rd} !== {1'b1, 32'd0}) $display("FAIL misalign_lh: got err=%b rdata=%h expected err=1 rdata=00000000", er, rd); else n_pass++;
      do_req(1'b1, 32'h012, 3'b010, 32'h99999999, rd, er, lat);
      n_checks++; if (er !== 1'b1) $display("FAIL misalign_sw: got err=%b expected 1", er); else n_pass++;
      do_req(1'b0, 32'h010, 3'b010, 32'd0, rd, er, lat);
      n_checks++; if (rd !== 32'hCAFEF00D) $display("FAIL misalign_no_write: got %h expected cafef00d", rd); else n_pass++;
`else
      do_req(1'b0, 32'h012, 3'b010, 32'd0, rd, er, lat);
      n_checks++; if ({er, rd} !== {1'b0, 32'hCAFEF00D}) $display("FAIL align_lw: got err=%b rdata=%h expected err=0 rdata=cafef00d", er, rd); else n_pass++;
      do_req(1'b0, 32'h011, 3'b001, 32'd0, rd, er, lat);
      n_checks++; if ({er, rd} !== {1'b0, 32'hFFFFF00D}) $display("FAIL align_lh: got err=%b rdata=%h expected err=0 rdata=fffff00d", er, rd); else n_pass++;
      do_req(1'b1, 32'h013, 3'b010, 32'h01020304, rd, er, lat);
      do_req(1'b0, 32'h010, 3'b010, 32'd0, rd, er, lat);
      n_checks++; if (rd !== 32'h01020304) $display("FAIL align_sw: got %h expected 01020304", rd); else n_pass++;
`endif
   endtask

   initial begin
      test_reset();
      test_word();
      test_extend();
      test_lanes();
      test_backpressure();
      test_reset_mid();
      test_illegal();
      test_misalign();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
